// File: rtl/rob_pkg.sv
// rob_pkg: shared types for the out-of-order reorder buffer.
//   cell_state_e : lifecycle of one table cell (FREE -> WAIT -> DONE -> FREE).
// The per-cell record (cell_t) depends on the block's width parameters and is
// therefore declared inside rob_ooo next to those parameters.
package rob_pkg;

    typedef enum logic [1:0] {
        FREE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } cell_state_e;

endpackage

// File: rtl/rob_alloc.sv
// rob_alloc: lowest-set-bit encoder over the free-cell vector.
//   free_vec : one bit per cell, 1 = cell is FREE
//   idx      : index of the lowest FREE cell (0 when none)
//   found    : at least one cell is FREE
module rob_alloc #(
    parameter int NUM_CELL = 16,
    parameter int TAG_W    = $clog2(NUM_CELL)
) (
    input  logic [NUM_CELL-1:0] free_vec,
    output logic [TAG_W-1:0]    idx,
    output logic                found
);

    // Scan high to low so the last hit written is the lowest index.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = NUM_CELL - 1; i >= 0; i--) begin
            if (free_vec[i]) begin
                idx   = TAG_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rob_ooo.sv
// rob_ooo: reorder buffer between a host master and an out-of-order memory.
// Each host request gets the lowest FREE cell; its index is the memory tag and
// is queued in an order FIFO. Memory fills may arrive in any order; responses
// are released to the host strictly in request (FIFO) order.
// Ports:
//   clk, rstn                      clock, async active-low reset
//   host_req_*  (valid/ready/id/addr)     host request channel
//   host_rsp_*  (valid/ready/id/data/err) in-order host response channel
//   mem_req_*   (valid/ready/tag/addr)    tagged memory request channel
//   mem_rsp_*   (valid/ready/tag/data/err) memory fill channel, ready tied 1
//   occupancy                       number of non-FREE cells
//   spurious                        sticky: a fill hit a non-WAIT cell
// Optional feature: define ROB_TIMEOUT_EN to expire WAIT cells after TIMEOUT
// cycles (cell becomes DONE with err=1, data=0).
module rob_ooo
    import rob_pkg::*;
#(
    parameter int NUM_CELL = 16,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int HID_W    = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          host_req_valid,
    output logic                          host_req_ready,
    input  logic [HID_W-1:0]              host_req_id,
    input  logic [ADDR_W-1:0]             host_req_addr,
    output logic                          host_rsp_valid,
    input  logic                          host_rsp_ready,
    output logic [HID_W-1:0]              host_rsp_id,
    output logic [DATA_W-1:0]             host_rsp_data,
    output logic                          host_rsp_err,
    output logic                          mem_req_valid,
    input  logic                          mem_req_ready,
    output logic [$clog2(NUM_CELL)-1:0]   mem_req_tag,
    output logic [ADDR_W-1:0]             mem_req_addr,
    input  logic                          mem_rsp_valid,
    output logic                          mem_rsp_ready,
    input  logic [$clog2(NUM_CELL)-1:0]   mem_rsp_tag,
    input  logic [DATA_W-1:0]             mem_rsp_data,
    input  logic                          mem_rsp_err,
    output logic [$clog2(NUM_CELL):0]     occupancy,
    output logic                          spurious
);

    localparam int TAG_W = $clog2(NUM_CELL);

    typedef struct packed {
        logic [HID_W-1:0]  hid;
        logic [DATA_W-1:0] data;
        logic              err;
        cell_state_e       state;
    } cell_t;

    cell_t                cells   [NUM_CELL];
    logic [TAG_W-1:0]     order_q [NUM_CELL];
    logic [TAG_W:0]       head_q, tail_q;   // extra MSB is the wrap bit
    logic                 spurious_q;

    logic [NUM_CELL-1:0]  free_vec;
    logic [TAG_W-1:0]     alloc_idx;
    logic                 alloc_found;
    logic [TAG_W-1:0]     head_tag;
    logic                 fifo_empty;
    logic                 push, pop, fill_hit;

    always_comb begin
        free_vec = '0;
        for (int i = 0; i < NUM_CELL; i++)
            free_vec[i] = (cells[i].state == FREE);
    end

    rob_alloc #(.NUM_CELL(NUM_CELL), .TAG_W(TAG_W)) u_alloc (
        .free_vec (free_vec),
        .idx      (alloc_idx),
        .found    (alloc_found)
    );

    // Allocation looks at pre-pop state, so a cell freed this cycle is only
    // allocatable next cycle. mem_req_valid must not depend on mem_req_ready.
    assign mem_req_valid  = host_req_valid && alloc_found;
    assign host_req_ready = alloc_found && mem_req_ready;
    assign mem_req_tag    = alloc_idx;
    assign mem_req_addr   = host_req_addr;
    assign mem_rsp_ready  = 1'b1;

    assign push       = host_req_valid && host_req_ready;
    assign fifo_empty = (head_q == tail_q);
    assign head_tag   = order_q[head_q[TAG_W-1:0]];

    assign host_rsp_valid = !fifo_empty && (cells[head_tag].state == DONE);
    assign host_rsp_id    = cells[head_tag].hid;
    assign host_rsp_data  = cells[head_tag].data;
    assign host_rsp_err   = cells[head_tag].err;
    assign pop            = host_rsp_valid && host_rsp_ready;

    // A pushed cell is FREE this cycle, so a fill aimed at it is not a hit.
    assign fill_hit = mem_rsp_valid && (cells[mem_rsp_tag].state == WAIT);

    // Every FIFO entry is exactly one non-FREE cell.
    assign occupancy = tail_q - head_q;
    assign spurious  = spurious_q;

`ifdef ROB_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    logic [TMR_W-1:0] timer_q [NUM_CELL];
    logic [NUM_CELL-1:0] expire;

    always_comb begin
        expire = '0;
        for (int i = 0; i < NUM_CELL; i++)
            expire[i] = (cells[i].state == WAIT) && (timer_q[i] == TMR_W'(TIMEOUT - 1));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_CELL; i++) timer_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CELL; i++) begin
                if (push && alloc_idx == TAG_W'(i)) timer_q[i] <= '0;
                else if (cells[i].state == WAIT)    timer_q[i] <= timer_q[i] + 1'b1;
            end
        end
    end
`endif

    // Push targets a FREE cell, fill a WAIT cell, pop a DONE cell: the three
    // branches never compete for the same cell. Expiry yields to a real fill.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_CELL; i++) begin
                cells[i].hid   <= '0;
                cells[i].data  <= '0;
                cells[i].err   <= 1'b0;
                cells[i].state <= FREE;
            end
        end else begin
            for (int i = 0; i < NUM_CELL; i++) begin
                if (push && alloc_idx == TAG_W'(i)) begin
                    cells[i].state <= WAIT;
                    cells[i].hid   <= host_req_id;
                    cells[i].data  <= '0;
                    cells[i].err   <= 1'b0;
                end else if (fill_hit && mem_rsp_tag == TAG_W'(i)) begin
                    cells[i].state <= DONE;
                    cells[i].data  <= mem_rsp_data;
                    cells[i].err   <= mem_rsp_err;
                end else if (pop && head_tag == TAG_W'(i)) begin
                    cells[i].state <= FREE;
`ifdef ROB_TIMEOUT_EN
                end else if (expire[i]) begin
                    cells[i].state <= DONE;
                    cells[i].data  <= '0;
                    cells[i].err   <= 1'b1;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q     <= '0;
            tail_q     <= '0;
            spurious_q <= 1'b0;
        end else begin
            if (push) tail_q <= tail_q + 1'b1;
            if (pop)  head_q <= head_q + 1'b1;
            if (mem_rsp_valid && !fill_hit) spurious_q <= 1'b1;
        end
    end

    // Entries are only read while valid, so the storage needs no reset.
    always_ff @(posedge clk) begin
        if (push) order_q[tail_q[TAG_W-1:0]] <= alloc_idx;
    end

endmodule

// File: tb/tb_rob_ooo.sv
module tb_rob_ooo;

    logic        clk = 1'b0;
    logic        rstn;
    logic        host_req_valid, host_req_ready;
    logic [3:0]  host_req_id;
    logic [31:0] host_req_addr;
    logic        host_rsp_valid, host_rsp_ready;
    logic [3:0]  host_rsp_id;
    logic [31:0] host_rsp_data;
    logic        host_rsp_err;
    logic        mem_req_valid, mem_req_ready;
    logic [3:0]  mem_req_tag;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid, mem_rsp_ready;
    logic [3:0]  mem_rsp_tag;
    logic [31:0] mem_rsp_data;
    logic        mem_rsp_err;
    logic [4:0]  occupancy;
    logic        spurious;

    rob_ooo #(.NUM_CELL(16), .ADDR_W(32), .DATA_W(32), .HID_W(4), .TIMEOUT(8)) dut (
        .clk(clk), .rstn(rstn),
        .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
        .host_req_id(host_req_id), .host_req_addr(host_req_addr),
        .host_rsp_valid(host_rsp_valid), .host_rsp_ready(host_rsp_ready),
        .host_rsp_id(host_rsp_id), .host_rsp_data(host_rsp_data), .host_rsp_err(host_rsp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_tag(mem_req_tag), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
        .mem_rsp_tag(mem_rsp_tag), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
        .occupancy(occupancy), .spurious(spurious)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    logic [31:0] exp_dat [16];
    logic        exp_err [16];
    int          vectors = 0;
    int          miscompares = 0;

    // Scoreboard: every accepted host response is checked against the oldest
    // expected entry.
    always @(negedge clk) begin
        #2;
        if (rstn && host_rsp_valid && host_rsp_ready) begin
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL rsp_unexpected got id=%0h data=%h", host_rsp_id, host_rsp_data);
            end else begin
                e = q.pop_front();
                if ({host_rsp_id, host_rsp_data, host_rsp_err} !== {e.id, e.data, e.err}) begin
                    miscompares++;
                    $display("FAIL rsp_order got id=%0h data=%h err=%b exp id=%0h data=%h err=%b",
                             host_rsp_id, host_rsp_data, host_rsp_err, e.id, e.data, e.err);
                end
            end
        end
    end

    task automatic push(input logic [3:0] id, input logic [31:0] addr, input logic err,
                        input logic [3:0] exp_tag);
        exp_t x;
        @(negedge clk);
        host_req_valid = 1'b1; host_req_id = id; host_req_addr = addr;
        #1;
        vectors++;
        if (host_req_ready !== 1'b1 || mem_req_valid !== 1'b1 || mem_req_tag !== exp_tag
            || mem_req_addr !== addr) begin
            miscompares++;
            $display("FAIL push_req rdy=%b mval=%b tag=%0d addr=%h exp tag=%0d addr=%h",
                     host_req_ready, mem_req_valid, mem_req_tag, mem_req_addr, exp_tag, addr);
        end
        exp_dat[exp_tag] = addr ^ 32'h5A5A_0000 ^ {28'h0, id};
        exp_err[exp_tag] = err;
        x.id = id; x.data = exp_dat[exp_tag]; x.err = err;
        q.push_back(x);
        @(posedge clk); #1;
        host_req_valid = 1'b0;
    endtask

    task automatic fill(input logic [3:0] tag);
        @(negedge clk);
        mem_rsp_valid = 1'b1; mem_rsp_tag = tag;
        mem_rsp_data = exp_dat[tag]; mem_rsp_err = exp_err[tag];
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
    endtask

    task automatic stray(input logic [3:0] tag);
        @(negedge clk);
        mem_rsp_valid = 1'b1; mem_rsp_tag = tag; mem_rsp_data = 32'hBAD0_BAD0; mem_rsp_err = 1'b0;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        host_req_valid = 0; host_req_id = 0; host_req_addr = 0;
        host_rsp_ready = 1; mem_req_ready = 1;
        mem_rsp_valid = 0; mem_rsp_tag = 0; mem_rsp_data = 0; mem_rsp_err = 0;
        #1;
        vectors++;
        if (host_rsp_valid !== 1'b0 || mem_req_valid !== 1'b0 || occupancy !== 5'd0
            || spurious !== 1'b0 || mem_rsp_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_state rsp_v=%b mreq_v=%b occ=%0d spur=%b mrsp_rdy=%b",
                     host_rsp_valid, mem_req_valid, occupancy, spurious, mem_rsp_ready);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_single;
        push(4'd3, 32'h100, 1'b0, 4'd0);
        vectors++;
        if (occupancy !== 5'd1) begin
            miscompares++; $display("FAIL single_occ1 got %0d exp 1", occupancy);
        end
        repeat (5) @(posedge clk);
        #1;
        vectors++;
        if (host_rsp_valid !== 1'b0) begin
            miscompares++; $display("FAIL single_early_valid got %b exp 0", host_rsp_valid);
        end
        fill(4'd0);
        vectors++;
        if (host_rsp_valid !== 1'b1) begin
            miscompares++; $display("FAIL single_latency valid got %b exp 1", host_rsp_valid);
        end
        @(posedge clk); #1;
        vectors++;
        if (occupancy !== 5'd0) begin
            miscompares++; $display("FAIL single_occ0 got %0d exp 0", occupancy);
        end
    endtask

    task automatic test_reverse;
        for (int i = 0; i < 4; i++) push(4'(i), 32'h200 + 32'(i * 4), 1'b0, 4'(i));
        for (int t = 3; t >= 1; t--) begin
            fill(4'(t));
            vectors++;
            if (host_rsp_valid !== 1'b0) begin
                miscompares++; $display("FAIL reverse_hold tag=%0d valid got %b exp 0", t, host_rsp_valid);
            end
        end
        fill(4'd0);
        vectors++;
        if (host_rsp_valid !== 1'b1) begin
            miscompares++; $display("FAIL reverse_release valid got %b exp 1", host_rsp_valid);
        end
        repeat (6) @(posedge clk);
        #1;
        vectors++;
        if (occupancy !== 5'd0) begin
            miscompares++; $display("FAIL reverse_drain occ got %0d exp 0", occupancy);
        end
    endtask

    task automatic test_full_backpressure;
        exp_t x;
        host_rsp_ready = 1'b0;
        for (int i = 0; i < 16; i++) push(4'(i), 32'h1000 + 32'(i * 16), 1'b0, 4'(i));
        @(negedge clk);
        host_req_valid = 1'b1; host_req_id = 4'hE; host_req_addr = 32'h2000;
        #1;
        vectors++;
        if (occupancy !== 5'd16 || host_req_ready !== 1'b0 || mem_req_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL full_state occ=%0d rdy=%b mval=%b exp 16 0 0", occupancy, host_req_ready, mem_req_valid);
        end
        for (int i = 0; i < 16; i++) fill(4'(i));
        // One-cycle ready: exactly one pop, push blocked in that cycle.
        @(negedge clk);
        host_rsp_ready = 1'b1;
        #1;
        vectors++;
        if (host_rsp_valid !== 1'b1 || host_req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full_pop_cycle rsp_v=%b req_rdy=%b exp 1 0", host_rsp_valid, host_req_ready);
        end
        @(posedge clk); #1;
        host_rsp_ready = 1'b0;
        @(negedge clk); #1;
        vectors++;
        if (host_req_ready !== 1'b1 || mem_req_tag !== 4'd0 || occupancy !== 5'd15) begin
            miscompares++;
            $display("FAIL full_realloc rdy=%b tag=%0d occ=%0d exp 1 0 15", host_req_ready, mem_req_tag, occupancy);
        end
        exp_dat[0] = 32'hC0FF_EE00; exp_err[0] = 1'b0;
        x.id = 4'hE; x.data = 32'hC0FF_EE00; x.err = 1'b0;
        q.push_back(x);
        @(posedge clk); #1;
        host_req_valid = 1'b0;
        vectors++;
        if (occupancy !== 5'd16) begin
            miscompares++; $display("FAIL full_refill occ got %0d exp 16", occupancy);
        end
        host_rsp_ready = 1'b1;
        fill(4'd0);
        for (int k = 0; k < 40 && occupancy != 5'd0; k++) @(negedge clk);
        vectors++;
        if (occupancy !== 5'd0) begin
            miscompares++; $display("FAIL full_drain_timeout occ got %0d exp 0", occupancy);
        end
    endtask

    task automatic test_spurious_err;
        vectors++;
        if (spurious !== 1'b0) begin
            miscompares++; $display("FAIL spur_pre got %b exp 0", spurious);
        end
        stray(4'd5);
        vectors++;
        if (spurious !== 1'b1 || occupancy !== 5'd0 || host_rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL spur_free spur=%b occ=%0d rsp_v=%b exp 1 0 0", spurious, occupancy, host_rsp_valid);
        end
        host_rsp_ready = 1'b0;
        push(4'd7, 32'h300, 1'b1, 4'd0);
        fill(4'd0);
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (host_rsp_valid !== 1'b1 || host_rsp_err !== 1'b1 || host_rsp_id !== 4'd7
                || host_rsp_data !== exp_dat[0]) begin
                miscompares++;
                $display("FAIL err_hold cyc=%0d v=%b err=%b id=%0h data=%h exp 1 1 7 %h",
                         k, host_rsp_valid, host_rsp_err, host_rsp_id, host_rsp_data, exp_dat[0]);
            end
            @(posedge clk); #1;
        end
        host_rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (occupancy !== 5'd0) begin
            miscompares++; $display("FAIL err_drain occ got %0d exp 0", occupancy);
        end
    endtask

    task automatic test_reset_midflight;
        push(4'd1, 32'h400, 1'b0, 4'd0);
        push(4'd2, 32'h404, 1'b0, 4'd1);
        push(4'd3, 32'h408, 1'b0, 4'd2);
        vectors++;
        if (occupancy !== 5'd3) begin
            miscompares++; $display("FAIL mid_occ3 got %0d exp 3", occupancy);
        end
        @(negedge clk);
        #3 rstn = 1'b0;
        #1;
        vectors++;
        if (occupancy !== 5'd0 || host_rsp_valid !== 1'b0 || mem_req_valid !== 1'b0 || spurious !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_async occ=%0d rsp_v=%b mreq_v=%b spur=%b exp 0 0 0 0",
                     occupancy, host_rsp_valid, mem_req_valid, spurious);
        end
        q.delete();
        @(negedge clk);
        rstn = 1'b1;
        stray(4'd1);
        vectors++;
        if (spurious !== 1'b1 || occupancy !== 5'd0) begin
            miscompares++; $display("FAIL mid_late_rsp spur=%b occ=%0d exp 1 0", spurious, occupancy);
        end
    endtask

`ifdef ROB_TIMEOUT_EN
    task automatic test_timeout;
        @(negedge clk); rstn = 1'b0;
        @(negedge clk); rstn = 1'b1;
        host_rsp_ready = 1'b0;
        push(4'd9, 32'h500, 1'b0, 4'd0);
        q[q.size()-1].data = 32'h0;
        q[q.size()-1].err  = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        vectors++;
        if (host_rsp_valid !== 1'b0) begin
            miscompares++; $display("FAIL timeout_early valid got %b exp 0", host_rsp_valid);
        end
        @(posedge clk); #1;
        vectors++;
        if (host_rsp_valid !== 1'b1 || host_rsp_err !== 1'b1 || host_rsp_data !== 32'h0) begin
            miscompares++;
            $display("FAIL timeout_expire v=%b err=%b data=%h exp 1 1 0", host_rsp_valid, host_rsp_err, host_rsp_data);
        end
        fill(4'd0);
        vectors++;
        if (spurious !== 1'b1 || host_rsp_data !== 32'h0 || host_rsp_err !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_late spur=%b data=%h err=%b exp 1 0 1", spurious, host_rsp_data, host_rsp_err);
        end
        host_rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (occupancy !== 5'd0) begin
            miscompares++; $display("FAIL timeout_drain occ got %0d exp 0", occupancy);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_reverse();
        test_full_backpressure();
        test_spurious_err();
        test_reset_midflight();
`ifdef ROB_TIMEOUT_EN
        test_timeout();
`endif
        repeat (2) @(negedge clk);
        vectors++;
        if (q.size() != 0) begin
            miscompares++; $display("FAIL scoreboard_leftover got %0d entries exp 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rob_ooo.md
# rob_ooo

Parametrised reorder buffer between a host master and an out-of-order memory slave. It allocates a table cell for each host request and forwards the request to memory tagged with the cell index. Memory responses may return in any order; the block releases them to the host strictly in request order. Compared with the earlier ROB it adds configurable widths, error propagation, an occupancy output, spurious-response detection and an optional per-cell timeout.

## Interface
- NUM_CELL, 16, table depth; power of two, ≥2; TAG_W = $clog2(NUM_CELL)
- ADDR_W, 32, request address width
- DATA_W, 32, response data width
- HID_W, 4, host transaction id width
- TIMEOUT, 255, cycles before a waiting cell expires (used only with ROB_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- host_req_valid / host_req_ready  in / out  1  host request handshake
- host_req_id  in  HID_W  host id, returned unchanged with the response
- host_req_addr  in  ADDR_W  address
- host_rsp_valid / host_rsp_ready  out / in  1  host response handshake
- host_rsp_id  out  HID_W  id of the released transaction
- host_rsp_data  out  DATA_W  response data
- host_rsp_err  out  1  error flag (memory error or timeout)
- mem_req_valid / mem_req_ready  out / in  1  memory request handshake
- mem_req_tag  out  TAG_W  allocated cell index
- mem_req_addr  out  ADDR_W  host_req_addr passthrough
- mem_rsp_valid  in  1  memory response strobe
- mem_rsp_ready  out  1  tied to 1
- mem_rsp_tag  in  TAG_W  cell index
- mem_rsp_data  in  DATA_W  data
- mem_rsp_err  in  1  memory error
- occupancy  out  TAG_W+1  number of non-FREE cells
- spurious  out  1  sticky; set when a response targets a non-WAIT cell

## Operation
- Cell state is FREE, WAIT or DONE. Each cell holds hid, data, err and state (plus a timer when ROB_TIMEOUT_EN is defined).
- Allocation: the lowest-index FREE cell is chosen.
  - mem_req_valid = host_req_valid && any cell FREE; it never depends on mem_req_ready.
  - host_req_ready = any cell FREE && mem_req_ready.
  - Push occurs on host_req_valid && host_req_ready: the cell goes to WAIT with hid captured, and its index is written to the order FIFO.
- Order FIFO: depth NUM_CELL, width TAG_W, built from a circular head/tail with a wrap bit. It can never overflow, because a push requires a FREE cell.
- Fill: mem_rsp_valid on a cell in WAIT captures data and err, and the cell moves to DONE.
  - A fill targeting a FREE or DONE cell is dropped and sets spurious. Only reset clears spurious.
- Release: host_rsp_valid = FIFO non-empty && the cell at the FIFO head is DONE. The host_rsp_* outputs are driven from that cell.
  - Pop occurs on host_rsp_valid && host_rsp_ready: the cell goes to FREE and head advances.
- Simultaneous events:
  - Push and pop in the same cycle are both performed. The popped cell is not allocatable until the next cycle, because allocation uses pre-pop state.
  - Push and fill in the same cycle target different cells by construction. A fill to the cell being pushed is spurious and is dropped; the push wins.
  - occupancy changes by +1 (push only), -1 (pop only) or 0 (both or neither).
- Full: occupancy == NUM_CELL forces host_req_ready = 0 and mem_req_valid = 0.

## Timing
- Reset state: all cells FREE and FIFO empty. Every valid output, spurious and occupancy reset to 0; mem_rsp_ready = 1.
- Request path is combinational: host request to mem_req_* takes 0 cycles.
- Fill to release latency: a fill in cycle N gives host_rsp_valid in cycle N+1 if that cell is at the head.
- Sustained throughput is one request and one response per cycle.
- The host_rsp_* outputs hold stable while valid && !ready.
- Reset mid-operation discards all cells. Any memory responses that arrive afterwards are flagged spurious.

## Configuration
- Macro ROB_TIMEOUT_EN:
  - Defined: each WAIT cell has a counter of width $clog2(TIMEOUT+1), cleared on push and incremented every cycle in WAIT.
    - When it reaches TIMEOUT, the cell moves to DONE with err = 1 and data = 0.
    - A later response for that cell is spurious.
    - A fill in the same cycle as expiry takes priority (real data, no error).
  - Undefined: no counters exist and WAIT persists until a fill arrives.

## Structure
- rob_pkg adds:
  - cell_state_e {FREE, WAIT, DONE}
  - parametrised cell_t fields (hid, data, err, state)
- Sub-module rob_alloc: NUM_CELL-wide lowest-set-bit encoder over the free vector, with outputs idx[TAG_W] and found.
- The order FIFO is inline.

## Test plan
- Single transaction:
  - Stimulus: push id=3, addr=0x100; memory responds tag 0, data 0xAA after 5 cycles.
  - Required: mem_req_tag = 0; host_rsp id=3, data=0xAA, err=0, one cycle after the fill; occupancy returns 0→1→0.
- Reverse order:
  - Stimulus: push 4 requests (ids 0–3); respond with tags 3, 2, 1, 0.
  - Required: host sees ids 0, 1, 2, 3 in order; host_rsp_valid first rises the cycle after tag 0's fill.
- Full plus backpressure:
  - Stimulus: 16 pushes with no responses, host_rsp_ready = 0.
  - Required: occupancy = 16 and host_req_ready = 0.
  - Then fill all cells and raise ready for 1 cycle: exactly one pop; a simultaneous push receives tag 0 only in the following cycle.
- Spurious and error:
  - Stimulus: response to a FREE tag 5.
  - Required: spurious = 1 and the table is unchanged.
  - Stimulus: response with mem_rsp_err = 1.
  - Required: host_rsp_err = 1.
- Timeout (ROB_TIMEOUT_EN, TIMEOUT = 8):
  - Stimulus: push with no response.
  - Required: host_rsp err = 1, data = 0 at push+9 cycles; a later response for that tag sets spurious.
- Reset mid-flight:
  - Stimulus: assert rstn low with 3 cells in WAIT.
  - Required: all outputs reach reset values asynchronously; occupancy = 0.
